// File: rtl/tx_re_mapper_if.sv
// Symbol-in / frame-out bundle between the modulator, the RE mapper and the IFFT.
// The mapper uses the slave modport; the symbol/IFFT side uses master.
interface tx_re_mapper_if #(
    parameter int SYM_W  = 16,
    parameter int N_BINS = 16
);
    logic [5:0]              i_Isc;
    logic signed [SYM_W-1:0] i_sym_real;
    logic signed [SYM_W-1:0] i_sym_imag;
    logic                    i_sym_valid;
    logic                    o_sym_ready;
    logic signed [SYM_W-1:0] o_IFFT_REAL      [N_BINS-1:0];
    logic signed [SYM_W-1:0] o_IFFT_IMAGINARY [N_BINS-1:0];
    logic                    o_valid;
    logic                    i_IFFT_ready;
    logic                    o_isc_err;

    modport master (
        output i_Isc, i_sym_real, i_sym_imag, i_sym_valid, i_IFFT_ready,
        input  o_sym_ready, o_IFFT_REAL, o_IFFT_IMAGINARY, o_valid, o_isc_err
    );

    modport slave (
        input  i_Isc, i_sym_real, i_sym_imag, i_sym_valid, i_IFFT_ready,
        output o_sym_ready, o_IFFT_REAL, o_IFFT_IMAGINARY, o_valid, o_isc_err
    );
endinterface

// File: rtl/tx_re_mapper.sv
// NB-IoT uplink RE mapper: packs 3/6/12 tones selected by Isc into a 16-bin IFFT frame.
// Optional macro TX_REM_DOUBLE_BUF_EN adds a ping-pong frame buffer for gapless streaming.
module tx_re_mapper #(
    parameter int SYM_W  = 16,
    parameter int N_BINS = 16
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          en,
    tx_re_mapper_if.slave bif
);
    localparam int N_USED = 12;

    typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

    state_t     r_state;
    logic [3:0] r_cnt;
    logic [3:0] r_n;
    logic [3:0] r_s;
    logic       r_valid;
    logic       r_ready;
    logic       r_isc_err;
`ifdef TX_REM_DOUBLE_BUF_EN
    logic       r_wr_sel;
    logic       r_rd_sel;
`endif

    logic       w_dec_ok;
    logic [3:0] w_dec_n;
    logic [3:0] w_dec_s;

    always_comb begin
        w_dec_ok = 1'b1;
        w_dec_n  = 4'd0;
        w_dec_s  = 4'd0;
        case (bif.i_Isc)
            6'd12:   begin w_dec_n = 4'd3;  w_dec_s = 4'd0; end
            6'd13:   begin w_dec_n = 4'd3;  w_dec_s = 4'd3; end
            6'd14:   begin w_dec_n = 4'd3;  w_dec_s = 4'd6; end
            6'd15:   begin w_dec_n = 4'd3;  w_dec_s = 4'd9; end
            6'd16:   begin w_dec_n = 4'd6;  w_dec_s = 4'd0; end
            6'd17:   begin w_dec_n = 4'd6;  w_dec_s = 4'd6; end
            6'd18:   begin w_dec_n = 4'd12; w_dec_s = 4'd0; end
            default: w_dec_ok = 1'b0;
        endcase
    end

    // In IDLE the live Isc decode is used; afterwards only the latched copy counts.
    wire       w_idle    = (r_state == IDLE);
    wire       w_acc     = bif.i_sym_valid && bif.o_sym_ready;
    wire       w_wr_en   = w_acc && (!w_idle || w_dec_ok);
    wire [3:0] w_cnt_inc = r_cnt + 4'd1;
    wire [3:0] w_bin     = (w_idle ? w_dec_s : r_s) + r_cnt;
    wire       w_last    = (w_cnt_inc == (w_idle ? w_dec_n : r_n));
    wire       w_take    = r_valid && bif.i_IFFT_ready;

    assign bif.o_sym_ready = r_ready && en;
    assign bif.o_valid     = r_valid && en;
    assign bif.o_isc_err   = r_isc_err;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_n       <= '0;
            r_s       <= '0;
            r_valid   <= 1'b0;
            r_ready   <= 1'b0;
            r_isc_err <= 1'b0;
`ifdef TX_REM_DOUBLE_BUF_EN
            r_wr_sel  <= 1'b0;
            r_rd_sel  <= 1'b0;
`endif
        end else if (!en) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_valid   <= 1'b0;
            r_ready   <= 1'b0;
            r_isc_err <= 1'b0;
`ifdef TX_REM_DOUBLE_BUF_EN
            r_wr_sel  <= 1'b0;
            r_rd_sel  <= 1'b0;
`endif
        end else begin
            r_isc_err <= w_acc && w_idle && !w_dec_ok;
            case (r_state)
                IDLE, COLLECT: begin
                    r_ready <= 1'b1;
`ifdef TX_REM_DOUBLE_BUF_EN
                    if (w_take) r_valid <= 1'b0;
`endif
                    if (w_wr_en) begin
                        if (w_idle) begin
                            r_n <= w_dec_n;
                            r_s <= w_dec_s;
                        end
                        if (w_last) begin
                            r_cnt <= '0;
`ifdef TX_REM_DOUBLE_BUF_EN
                            // Present immediately if the output slot is free this edge.
                            if (!r_valid || w_take) begin
                                r_state  <= IDLE;
                                r_valid  <= 1'b1;
                                r_rd_sel <= r_wr_sel;
                                r_wr_sel <= !r_wr_sel;
                            end else begin
                                r_state <= HOLD;
                                r_ready <= 1'b0;
                            end
`else
                            r_state <= HOLD;
                            r_valid <= 1'b1;
                            r_ready <= 1'b0;
`endif
                        end else begin
                            r_state <= COLLECT;
                            r_cnt   <= w_cnt_inc;
                        end
                    end
                end
                HOLD: begin
                    if (w_take) begin
                        r_state <= IDLE;
                        r_ready <= 1'b1;
`ifdef TX_REM_DOUBLE_BUF_EN
                        r_rd_sel <= r_wr_sel;
                        r_wr_sel <= !r_wr_sel;
`else
                        r_valid <= 1'b0;
`endif
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_BINS; gi++) begin : g_bin
            if (gi < N_USED) begin : g_used
                wire w_hit = w_wr_en && (w_bin == 4'(gi));
`ifdef TX_REM_DOUBLE_BUF_EN
                logic signed [SYM_W-1:0] r_re [2];
                logic signed [SYM_W-1:0] r_im [2];

                always_ff @(posedge i_clk or negedge i_rst_n) begin
                    if (!i_rst_n) begin
                        r_re[0] <= '0;
                        r_re[1] <= '0;
                        r_im[0] <= '0;
                        r_im[1] <= '0;
                    end else begin
                        for (int b = 0; b < 2; b++) begin
                            if (!en || (w_take && r_rd_sel == 1'(b))) begin
                                r_re[b] <= '0;
                                r_im[b] <= '0;
                            end else if (w_hit && r_wr_sel == 1'(b)) begin
                                r_re[b] <= bif.i_sym_real;
                                r_im[b] <= bif.i_sym_imag;
                            end
                        end
                    end
                end

                assign bif.o_IFFT_REAL[gi]      = r_re[r_rd_sel];
                assign bif.o_IFFT_IMAGINARY[gi] = r_im[r_rd_sel];
`else
                logic signed [SYM_W-1:0] r_re;
                logic signed [SYM_W-1:0] r_im;

                always_ff @(posedge i_clk or negedge i_rst_n) begin
                    if (!i_rst_n) begin
                        r_re <= '0;
                        r_im <= '0;
                    end else if (!en || w_take) begin
                        r_re <= '0;
                        r_im <= '0;
                    end else if (w_hit) begin
                        r_re <= bif.i_sym_real;
                        r_im <= bif.i_sym_imag;
                    end
                end

                assign bif.o_IFFT_REAL[gi]      = r_re;
                assign bif.o_IFFT_IMAGINARY[gi] = r_im;
`endif
            end else begin : g_guard
                assign bif.o_IFFT_REAL[gi]      = '0;
                assign bif.o_IFFT_IMAGINARY[gi] = '0;
            end
        end
    endgenerate
endmodule

// File: tb/tb_tx_re_mapper.sv
// Bench for tx_re_mapper: directed scenarios plus randomized frames checked against an Isc-table model.
`timescale 1ns/1ps
module tb_tx_re_mapper;
    localparam int SYM_W  = 16;
    localparam int N_BINS = 16;
`ifdef TX_REM_DOUBLE_BUF_EN
    localparam logic DBL = 1'b1;
`else
    localparam logic DBL = 1'b0;
`endif

    typedef logic [N_BINS*2*SYM_W-1:0] frame_t;

    logic i_clk   = 1'b0;
    logic i_rst_n = 1'b1;
    logic en      = 1'b0;

    tx_re_mapper_if #(.SYM_W(SYM_W), .N_BINS(N_BINS)) bif ();

    tx_re_mapper #(.SYM_W(SYM_W), .N_BINS(N_BINS)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .en      (en),
        .bif     (bif)
    );

    always #5 i_clk = ~i_clk;

    int     n_vec = 0;
    int     n_err = 0;
    int     q_re[$];
    int     q_im[$];
    frame_t zero_f = '0;

    // Reference model: tones n and start bin s straight from the Isc table.
    function automatic int isc_n(int isc);
        if (isc >= 12 && isc <= 15) return 3;
        if (isc == 16 || isc == 17) return 6;
        if (isc == 18) return 12;
        return 0;
    endfunction

    function automatic int isc_s(int isc);
        if (isc >= 12 && isc <= 15) return 3 * (isc - 12);
        if (isc == 16 || isc == 17) return 6 * (isc - 16);
        return 0;
    endfunction

    function automatic frame_t model_frame(int isc, int sr[$], int si[$]);
        frame_t f = '0;
        int n = isc_n(isc);
        int s = isc_s(isc);
        for (int k = 0; k < n; k++) begin
            f[(s+k)*2*SYM_W +: SYM_W]         = SYM_W'(sr[k]);
            f[(s+k)*2*SYM_W + SYM_W +: SYM_W] = SYM_W'(si[k]);
        end
        return f;
    endfunction

    function automatic frame_t dut_frame();
        frame_t f;
        for (int b = 0; b < N_BINS; b++) begin
            f[b*2*SYM_W +: SYM_W]         = bif.o_IFFT_REAL[b];
            f[b*2*SYM_W + SYM_W +: SYM_W] = bif.o_IFFT_IMAGINARY[b];
        end
        return f;
    endfunction

    function automatic int rnd_sym();
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive_sym(input int isc, input int re, input int im);
        bif.i_Isc       = 6'(isc);
        bif.i_sym_real  = SYM_W'(re);
        bif.i_sym_imag  = SYM_W'(im);
        bif.i_sym_valid = 1'b1;
    endtask

    task automatic idle_sym();
        bif.i_sym_valid = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        i_rst_n = 1'b0;
        en      = 1'b1;
        tick();
        tick();
        n_vec++; if (bif.o_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", bif.o_valid); end
        n_vec++; if (bif.o_sym_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b expected 0", bif.o_sym_ready); end
        n_vec++; if (bif.o_isc_err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b expected 0", bif.o_isc_err); end
        n_vec++; if (dut_frame() !== zero_f) begin n_err++; $display("FAIL reset_frame: got %h expected %h", dut_frame(), zero_f); end
        i_rst_n = 1'b1;
        #1;
        n_vec++; if (bif.o_sym_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready_pre_edge: got %b expected 0", bif.o_sym_ready); end
        tick();
        n_vec++; if (bif.o_sym_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready_rise: got %b expected 1", bif.o_sym_ready); end
        $display("reset: done");
    endtask

    task automatic test_isc13();
        frame_t exp_f;
        q_re.delete(); q_im.delete();
        bif.i_IFFT_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            n_vec++; if (bif.o_sym_ready !== 1'b1) begin n_err++; $display("FAIL isc13_ready k=%0d: got %b expected 1", k, bif.o_sym_ready); end
            drive_sym(13, 100*(k+1), -100*(k+1));
            q_re.push_back(100*(k+1)); q_im.push_back(-100*(k+1));
            tick();
        end
        idle_sym();
        exp_f = model_frame(13, q_re, q_im);
        n_vec++; if (bif.o_valid !== 1'b1) begin n_err++; $display("FAIL isc13_valid: got %b expected 1", bif.o_valid); end
        n_vec++; if (dut_frame() !== exp_f) begin n_err++; $display("FAIL isc13_frame: got %h expected %h", dut_frame(), exp_f); end
        tick();
        n_vec++; if (bif.o_valid !== 1'b0) begin n_err++; $display("FAIL isc13_valid_drop: got %b expected 0", bif.o_valid); end
        bif.i_IFFT_ready = 1'b0;
        $display("isc13: frame bins 3..5");
    endtask

    task automatic test_isc18_hold();
        frame_t exp_f;
        q_re.delete(); q_im.delete();
        bif.i_IFFT_ready = 1'b0;
        for (int k = 0; k < 12; k++) begin
            drive_sym(18, k, -k);
            q_re.push_back(k); q_im.push_back(-k);
            tick();
        end
        idle_sym();
        exp_f = model_frame(18, q_re, q_im);
        for (int c = 0; c < 5; c++) begin
            n_vec++; if (bif.o_valid !== 1'b1) begin n_err++; $display("FAIL isc18_hold_valid c=%0d: got %b expected 1", c, bif.o_valid); end
            n_vec++; if (dut_frame() !== exp_f) begin n_err++; $display("FAIL isc18_hold_frame c=%0d: got %h expected %h", c, dut_frame(), exp_f); end
            n_vec++; if (bif.o_sym_ready !== DBL) begin n_err++; $display("FAIL isc18_hold_ready c=%0d: got %b expected %b", c, bif.o_sym_ready, DBL); end
            tick();
        end
        n_vec++; if (bif.o_valid !== 1'b1) begin n_err++; $display("FAIL isc18_valid_before_take: got %b expected 1", bif.o_valid); end
        bif.i_IFFT_ready = 1'b1;
        tick();
        bif.i_IFFT_ready = 1'b0;
        n_vec++; if (bif.o_valid !== 1'b0) begin n_err++; $display("FAIL isc18_valid_after_take: got %b expected 0", bif.o_valid); end
        $display("isc18: 12-tone frame held 5 cycles");
    endtask

    task automatic test_isc_err();
        frame_t exp_f;
        n_vec++; if (bif.o_sym_ready !== 1'b1) begin n_err++; $display("FAIL isc20_ready: got %b expected 1", bif.o_sym_ready); end
        drive_sym(20, 55, -55);
        tick();
        idle_sym();
        n_vec++; if (bif.o_isc_err !== 1'b1) begin n_err++; $display("FAIL isc20_err_pulse: got %b expected 1", bif.o_isc_err); end
        n_vec++; if (bif.o_valid !== 1'b0) begin n_err++; $display("FAIL isc20_no_valid: got %b expected 0", bif.o_valid); end
        tick();
        n_vec++; if (bif.o_isc_err !== 1'b0) begin n_err++; $display("FAIL isc20_err_one_cycle: got %b expected 0", bif.o_isc_err); end
        q_re.delete(); q_im.delete();
        bif.i_IFFT_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            q_re.push_back(rnd_sym()); q_im.push_back(rnd_sym());
            drive_sym(16, q_re[k], q_im[k]);
            tick();
        end
        idle_sym();
        exp_f = model_frame(16, q_re, q_im);
        n_vec++; if (bif.o_valid !== 1'b1) begin n_err++; $display("FAIL isc16_valid: got %b expected 1", bif.o_valid); end
        n_vec++; if (dut_frame() !== exp_f) begin n_err++; $display("FAIL isc16_frame: got %h expected %h", dut_frame(), exp_f); end
        tick();
        bif.i_IFFT_ready = 1'b0;
        $display("isc20: error pulse, then isc16 frame");
    endtask

    task automatic test_isc_change();
        frame_t exp_f;
        q_re.delete(); q_im.delete();
        bif.i_IFFT_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            q_re.push_back(rnd_sym()); q_im.push_back(rnd_sym());
            drive_sym((k < 2) ? 17 : 12, q_re[k], q_im[k]);
            tick();
        end
        idle_sym();
        exp_f = model_frame(17, q_re, q_im);
        n_vec++; if (bif.o_valid !== 1'b1) begin n_err++; $display("FAIL isc_change_valid: got %b expected 1", bif.o_valid); end
        n_vec++; if (dut_frame() !== exp_f) begin n_err++; $display("FAIL isc_change_frame: got %h expected %h", dut_frame(), exp_f); end
        tick();
        bif.i_IFFT_ready = 1'b0;
        $display("isc_change: latched isc17 kept");
    endtask

    task automatic test_abort_en();
        frame_t exp_f;
        for (int k = 0; k < 2; k++) begin
            drive_sym(14, 1000 + k, -1000 - k);
            tick();
        end
        idle_sym();
        en = 1'b0;
        #1;
        n_vec++; if (bif.o_sym_ready !== 1'b0) begin n_err++; $display("FAIL abort_ready_en_low: got %b expected 0", bif.o_sym_ready); end
        n_vec++; if (bif.o_valid !== 1'b0) begin n_err++; $display("FAIL abort_valid_en_low: got %b expected 0", bif.o_valid); end
        tick();
        n_vec++; if (dut_frame() !== zero_f) begin n_err++; $display("FAIL abort_flush: got %h expected %h", dut_frame(), zero_f); end
        en = 1'b1;
        tick();
        n_vec++; if (bif.o_sym_ready !== 1'b1) begin n_err++; $display("FAIL abort_ready_back: got %b expected 1", bif.o_sym_ready); end
        q_re.delete(); q_im.delete();
        bif.i_IFFT_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            q_re.push_back(rnd_sym()); q_im.push_back(rnd_sym());
            drive_sym(12, q_re[k], q_im[k]);
            tick();
        end
        idle_sym();
        exp_f = model_frame(12, q_re, q_im);
        n_vec++; if (bif.o_valid !== 1'b1) begin n_err++; $display("FAIL abort_new_valid: got %b expected 1", bif.o_valid); end
        n_vec++; if (dut_frame() !== exp_f) begin n_err++; $display("FAIL abort_new_frame: got %h expected %h", dut_frame(), exp_f); end
        tick();
        bif.i_IFFT_ready = 1'b0;
        $display("abort_en: partial frame discarded");
    endtask

    task automatic test_reset_hold();
        frame_t exp_f;
        q_re.delete(); q_im.delete();
        bif.i_IFFT_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            q_re.push_back(rnd_sym()); q_im.push_back(rnd_sym());
            drive_sym(15, q_re[k], q_im[k]);
            tick();
        end
        idle_sym();
        exp_f = model_frame(15, q_re, q_im);
        n_vec++; if (dut_frame() !== exp_f) begin n_err++; $display("FAIL rst_hold_frame: got %h expected %h", dut_frame(), exp_f); end
        i_rst_n = 1'b0;
        #1;
        n_vec++; if (bif.o_valid !== 1'b0) begin n_err++; $display("FAIL rst_hold_valid: got %b expected 0", bif.o_valid); end
        n_vec++; if (bif.o_sym_ready !== 1'b0) begin n_err++; $display("FAIL rst_hold_ready: got %b expected 0", bif.o_sym_ready); end
        n_vec++; if (dut_frame() !== zero_f) begin n_err++; $display("FAIL rst_hold_clear: got %h expected %h", dut_frame(), zero_f); end
        #2;
        i_rst_n = 1'b1;
        tick();
        n_vec++; if (bif.o_sym_ready !== 1'b1) begin n_err++; $display("FAIL rst_hold_ready_back: got %b expected 1", bif.o_sym_ready); end
        $display("reset_hold: async clear in HOLD");
    endtask

    task automatic test_random();
        int     isc;
        int     n;
        int     gap;
        frame_t exp_f;
        for (int f = 0; f < 40; f++) begin
            q_re.delete(); q_im.delete();
            bif.i_IFFT_ready = 1'b0;
            if ($urandom_range(0, 5) == 0) begin
                do isc = int'($urandom_range(0, 63)); while (isc >= 12 && isc <= 18);
                n_vec++; if (bif.o_sym_ready !== 1'b1) begin n_err++; $display("FAIL rnd_err_ready f=%0d: got %b expected 1", f, bif.o_sym_ready); end
                drive_sym(isc, rnd_sym(), rnd_sym());
                tick();
                idle_sym();
                n_vec++; if (bif.o_isc_err !== 1'b1) begin n_err++; $display("FAIL rnd_err_pulse f=%0d isc=%0d: got %b expected 1", f, isc, bif.o_isc_err); end
                n_vec++; if (bif.o_valid !== 1'b0) begin n_err++; $display("FAIL rnd_err_valid f=%0d: got %b expected 0", f, bif.o_valid); end
                tick();
                n_vec++; if (bif.o_isc_err !== 1'b0) begin n_err++; $display("FAIL rnd_err_clear f=%0d: got %b expected 0", f, bif.o_isc_err); end
                $display("rnd frame %0d: invalid isc %0d", f, isc);
            end else begin
                isc = int'($urandom_range(12, 18));
                n   = isc_n(isc);
                for (int k = 0; k < n; k++) begin
                    gap = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 2)) : 0;
                    for (int g = 0; g < gap; g++) begin
                        idle_sym();
                        bif.i_Isc = 6'($urandom_range(0, 63));
                        tick();
                    end
                    q_re.push_back(rnd_sym()); q_im.push_back(rnd_sym());
                    n_vec++; if (bif.o_sym_ready !== 1'b1) begin n_err++; $display("FAIL rnd_ready f=%0d k=%0d: got %b expected 1", f, k, bif.o_sym_ready); end
                    drive_sym((k == 0) ? isc : int'($urandom_range(0, 63)), q_re[k], q_im[k]);
                    tick();
                end
                idle_sym();
                exp_f = model_frame(isc, q_re, q_im);
                gap = int'($urandom_range(0, 3));
                for (int c = 0; c <= gap; c++) begin
                    n_vec++; if (bif.o_valid !== 1'b1) begin n_err++; $display("FAIL rnd_valid f=%0d c=%0d: got %b expected 1", f, c, bif.o_valid); end
                    n_vec++; if (dut_frame() !== exp_f) begin n_err++; $display("FAIL rnd_frame f=%0d isc=%0d: got %h expected %h", f, isc, dut_frame(), exp_f); end
                    n_vec++; if (bif.o_sym_ready !== DBL) begin n_err++; $display("FAIL rnd_hold_ready f=%0d: got %b expected %b", f, bif.o_sym_ready, DBL); end
                    if (c == gap) bif.i_IFFT_ready = 1'b1;
                    tick();
                end
                bif.i_IFFT_ready = 1'b0;
                n_vec++; if (bif.o_valid !== 1'b0) begin n_err++; $display("FAIL rnd_taken f=%0d: got %b expected 0", f, bif.o_valid); end
                n_vec++; if (dut_frame() !== zero_f) begin n_err++; $display("FAIL rnd_cleared f=%0d: got %h expected %h", f, dut_frame(), zero_f); end
                $display("rnd frame %0d: isc %0d, %0d tones, hold %0d", f, isc, n, gap);
            end
        end
    endtask

`ifdef TX_REM_DOUBLE_BUF_EN
    task automatic test_back_to_back();
        int     sr[12];
        int     si[12];
        frame_t exp_f;
        for (int k = 0; k < 12; k++) begin
            sr[k] = rnd_sym();
            si[k] = rnd_sym();
        end
        bif.i_IFFT_ready = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            n_vec++; if (bif.o_sym_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready e=%0d: got %b expected 1", e, bif.o_sym_ready); end
            drive_sym(12, sr[e-1], si[e-1]);
            tick();
            n_vec++; if (bif.o_valid !== (e % 3 == 0)) begin n_err++; $display("FAIL b2b_valid e=%0d: got %b expected %b", e, bif.o_valid, (e % 3 == 0)); end
            if (e % 3 == 0) begin
                q_re.delete(); q_im.delete();
                for (int j = e - 3; j < e; j++) begin
                    q_re.push_back(sr[j]); q_im.push_back(si[j]);
                end
                exp_f = model_frame(12, q_re, q_im);
                n_vec++; if (dut_frame() !== exp_f) begin n_err++; $display("FAIL b2b_frame e=%0d: got %h expected %h", e, dut_frame(), exp_f); end
            end
        end
        idle_sym();
        tick();
        bif.i_IFFT_ready = 1'b0;
        n_vec++; if (bif.o_valid !== 1'b0) begin n_err++; $display("FAIL b2b_end_valid: got %b expected 0", bif.o_valid); end
        $display("back_to_back: 4 frames streamed");
    endtask
`endif

    initial begin
        bif.i_Isc        = '0;
        bif.i_sym_real   = '0;
        bif.i_sym_imag   = '0;
        bif.i_sym_valid  = 1'b0;
        bif.i_IFFT_ready = 1'b0;
        test_reset();
        test_isc13();
        test_isc18_hold();
        test_isc_err();
        test_isc_change();
        test_abort_en();
        test_reset_hold();
        test_random();
`ifdef TX_REM_DOUBLE_BUF_EN
        test_back_to_back();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion expected finish before 2ms");
        $fatal(1, "simulation time limit reached");
    end
endmodule

// File: doc/tx_re_mapper.md
# tx_re_mapper

Transmit-side resource-element mapper for the NB-IoT uplink chain. It accepts modulated symbols one per cycle from the modulator and assembles them into a 16-bin IFFT input frame. The subcarrier allocation is selected by the 6-bit subcarrier indication `i_Isc` (3, 6 or 12 tones). It presents the completed frame to the IFFT with a valid/ready handshake. It is the transmit counterpart of the receive-side subcarrier extractor and uses the same `i_Isc` code table.

## Interface
- `SYM_W`, default 16: width of the signed real and imaginary sample components.
- `N_BINS`, default 16: number of IFFT bins per frame. Fixed at 16; no other value is supported.

- `i_clk`  input  1  clock. All registers update on the rising edge.
- `i_rst_n`  input  1  reset, asynchronous, active-low.
- `en`  input  1  block enable. Low means a synchronous flush to IDLE.
- `i_Isc`  input  6  subcarrier indication, sampled at the start of each frame.
- `i_sym_real`  input  SYM_W  signed real part of the incoming symbol.
- `i_sym_imag`  input  SYM_W  signed imaginary part of the incoming symbol.
- `i_sym_valid`  input  1  the incoming symbol is valid.
- `o_sym_ready`  output  1  the mapper can accept a symbol.
- `o_IFFT_REAL[N_BINS-1:0]`  output  SYM_W each  frame, real parts.
- `o_IFFT_IMAGINARY[N_BINS-1:0]`  output  SYM_W each  frame, imaginary parts.
- `o_valid`  output  1  the frame is valid. Held high until accepted.
- `i_IFFT_ready`  input  1  the IFFT accepts the frame.
- `o_isc_err`  output  1  one-cycle pulse: unsupported `i_Isc` at frame start.

## Operation
- Isc table (tone count n, start bin s):
  - 12: n=3, s=0
  - 13: n=3, s=3
  - 14: n=3, s=6
  - 15: n=3, s=9
  - 16: n=6, s=0
  - 17: n=6, s=6
  - 18: n=12, s=0
  - any other code is invalid.
- Frame mapping:
  - Symbol k of a frame (k = 0..n-1) goes to bin s+k.
  - All other bins are 0.
  - Bins 12..15 are always 0 (guard).
- A symbol is accepted when `i_sym_valid && o_sym_ready`.
- FSM states: IDLE, COLLECT, HOLD.
  - IDLE: `o_sym_ready`=1. On the first accepted symbol, latch `i_Isc`.
    - Valid code: write the symbol to bin s, count=1. Go to COLLECT, or go directly to HOLD if n==1 (never occurs for the table above).
    - Invalid code: drop the symbol, pulse `o_isc_err`, stay in IDLE.
  - COLLECT: `o_sym_ready`=1. Each accepted symbol is written to bin s+count and count increments. When the n-th symbol is accepted, go to HOLD.
  - HOLD: `o_sym_ready`=0 and `o_valid`=1. When `i_IFFT_ready`=1, clear the frame buffer to zero and go to IDLE.
- The latched Isc is used for the whole frame. Changes to `i_Isc` mid-frame are ignored.
- `en`=0 from any state:
  - next state IDLE, count=0, buffer cleared;
  - `o_valid`=0 and `o_sym_ready`=0 while `en`=0;
  - a frame in progress is discarded.
- Data passes through unmodified: no scaling and no saturation.

## Timing
- Reset values:
  - all frame bins 0;
  - `o_valid`=0, `o_sym_ready`=0, `o_isc_err`=0;
  - state IDLE, count 0.
- `o_sym_ready` rises on the first clock edge after reset release when `en`=1.
- Latency: `o_valid` goes high in the cycle after the edge that accepts the last symbol. Minimum frame period is n+1 cycles (n collect cycles plus 1 hold cycle when `i_IFFT_ready` is held high).
- Frame outputs are stable for as long as `o_valid`=1.
- `o_isc_err` goes high in the cycle after the offending acceptance and lasts exactly one cycle.
- Reset asserted mid-frame: the asynchronous clear takes effect immediately and all outputs go to their reset values.
- `i_sym_valid` gaps in COLLECT: the FSM waits with count unchanged. There is no timeout.

## Configuration
- Macro `TX_REM_DOUBLE_BUF_EN`.
- Defined:
  - A second frame buffer is added.
  - In HOLD, `o_sym_ready` stays 1 and the next frame collects into the alternate buffer.
  - If the alternate frame completes before the held frame is accepted, `o_sym_ready` drops until the handover.
  - On `i_IFFT_ready`, the completed alternate frame is presented in the next cycle with no bubble.
  - Back-to-back frame period is n cycles.
- Undefined: single buffer, behaviour exactly as described above.

## Test plan
- Isc=13 case:
  - Stimulus: symbols (100,-100), (200,-200), (300,-300) on consecutive cycles, `i_IFFT_ready`=1.
  - Required: in the next cycle `o_valid`=1, bins 3/4/5 hold those values and all other bins are 0. After one cycle `o_valid`=0.
- Isc=18 case:
  - Stimulus: 12 symbols with real=k, imag=-k, `i_IFFT_ready`=0 for 5 cycles.
  - Required: bins 0..11 = k/-k and bins 12..15 = 0. `o_valid` and the data are held for 5 cycles and `o_sym_ready`=0 throughout.
- Isc=20 case:
  - Stimulus: one symbol.
  - Required: `o_isc_err` is a 1-cycle pulse, there is no `o_valid`, and a following Isc=16 frame of 6 symbols maps correctly to bins 0..5.
- Isc change mid-frame:
  - Stimulus: Isc=17 at the first symbol, then Isc changes to 12 after the 2nd symbol.
  - Required: all 6 symbols land in bins 6..11.
- Abort cases:
  - Stimulus: `en`=0 after 2 of 3 symbols (Isc=14), then `en`=1 and a full frame. Separately, `i_rst_n`=0 in HOLD.
  - Required: the first frame is discarded and only the new frame appears. With reset, outputs clear immediately.
- Back-to-back with `TX_REM_DOUBLE_BUF_EN`:
  - Stimulus: Isc=12 frames streamed continuously, `i_IFFT_ready`=1.
  - Required: `o_valid` is high on every 3rd cycle with no bubble, and `o_sym_ready` never drops.
